// File: rtl/rvvi_pkg.sv
// Shared widths, header layout, FSM state type and sizing helpers for the
// RVVI trace stream packer.
package rvvi_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam int GPR_FIELD_W  = DEFAULT_XLEN + 8;
  localparam int CSR_FIELD_W  = DEFAULT_XLEN + 16;

  // Header beat layout (zero-extended to the beat width)
  localparam int HDR_BEATS_LSB = 0;
  localparam int HDR_BEATS_W   = 16;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_SEQ_W     = 8;
  localparam int HDR_DROP_LSB  = 24;
  localparam int HDR_DROP_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } pack_state_t;

  function automatic int gpr_field_w(input int xlen);
    return xlen + 8;
  endfunction

  function automatic int csr_field_w(input int xlen);
    return xlen + 16;
  endfunction

  // Longest possible packed frame: required block, both register writes, all CSRs
  function automatic int max_payload_len(input int req_w, input int xlen, input int max_csrs);
    return req_w + 2 * gpr_field_w(xlen) + max_csrs * csr_field_w(xlen);
  endfunction

  function automatic int max_beats(input int max_len, input int beat_w);
    return (max_len + beat_w - 1) / beat_w;
  endfunction

  // Width able to hold any beat count 0..max_beats
  function automatic int beat_idx_w(input int max_len, input int beat_w);
    return $clog2(max_beats(max_len, beat_w) + 1);
  endfunction

endpackage

// File: rtl/rvvi_field_compactor.sv
// Combinational packer: drops absent fields of a retire frame, places the
// present ones contiguously above the required block, and reports the packed
// length and the number of payload beats it occupies.
module rvvi_field_compactor
  import rvvi_pkg::*;
#(
  parameter  int XLEN     = 64,
  parameter  int MAX_CSRS = 5,
  parameter  int BEAT_W   = 32,
  parameter  int REQ_W    = 192 + XLEN,
  localparam int GF_W     = gpr_field_w(XLEN),
  localparam int CF_W     = csr_field_w(XLEN),
  localparam int MAX_L    = max_payload_len(REQ_W, XLEN, MAX_CSRS),
  localparam int LEN_W    = $clog2(MAX_L + 1),
  localparam int BCW      = beat_idx_w(MAX_L, BEAT_W),
  localparam int CNT_W    = $clog2(MAX_CSRS + 1)
) (
  input  logic [REQ_W-1:0]         required,
  input  logic                     gpr_wen,
  input  logic [GF_W-1:0]          gpr,
  input  logic                     fpr_wen,
  input  logic [GF_W-1:0]          fpr,
  input  logic [CNT_W-1:0]         csr_count,
  input  logic [MAX_CSRS*CF_W-1:0] csrs,
  output logic [MAX_L-1:0]         payload,
  output logic [LEN_W-1:0]         len,
  output logic [BCW-1:0]           beats
);

  logic [LEN_W-1:0] off;
  logic [CNT_W-1:0] csr_n;
  logic [LEN_W:0]   len_rounded;

  // Walk the fields in order, OR each present one in at the running offset
  always_comb begin
    payload = '0;
    payload[REQ_W-1:0] = required;
    off = LEN_W'(REQ_W);
    csr_n = (csr_count > CNT_W'(MAX_CSRS)) ? CNT_W'(MAX_CSRS) : csr_count;
    if (gpr_wen) begin
      payload = payload | (MAX_L'(gpr) << off);
      off = off + LEN_W'(GF_W);
    end
    if (fpr_wen) begin
      payload = payload | (MAX_L'(fpr) << off);
      off = off + LEN_W'(GF_W);
    end
    for (int i = 0; i < MAX_CSRS; i++) begin
      if (CNT_W'(i) < csr_n) begin
        payload = payload | (MAX_L'(csrs[i*CF_W +: CF_W]) << off);
        off = off + LEN_W'(CF_W);
      end
    end
    len = off;
  end

  // Beat count is the packed length rounded up to whole beats
  assign len_rounded = {1'b0, len} + (LEN_W + 1)'(BEAT_W - 1);
  assign beats       = BCW'(len_rounded / (LEN_W + 1)'(BEAT_W));

endmodule

// File: rtl/rvvi_stream_packer.sv
// RVVI retire-frame stream packer: accepts one frame, holds its packed
// payload, and emits a header beat followed by the payload beats on a
// valid/ready stream, with optional lossy operation while busy.
module rvvi_stream_packer
  import rvvi_pkg::*;
#(
  parameter  int XLEN         = 64,
  parameter  int MAX_CSRS     = 5,
  parameter  int BEAT_W       = 32,
  parameter  int REQ_W        = 192 + XLEN,
  parameter  int DROP_ON_FULL = 0,
  parameter  int SEQ_W        = 16,
  localparam int GF_W         = gpr_field_w(XLEN),
  localparam int CF_W         = csr_field_w(XLEN),
  localparam int MAX_L        = max_payload_len(REQ_W, XLEN, MAX_CSRS),
  localparam int LEN_W        = $clog2(MAX_L + 1),
  localparam int MAX_BEATS    = max_beats(MAX_L, BEAT_W),
  localparam int HOLD_W       = MAX_BEATS * BEAT_W,
  localparam int BCW          = beat_idx_w(MAX_L, BEAT_W),
  localparam int CNT_W        = $clog2(MAX_CSRS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REQ_W-1:0]         in_required,
  input  logic                     in_gpr_wen,
  input  logic [GF_W-1:0]          in_gpr,
  input  logic                     in_fpr_wen,
  input  logic [GF_W-1:0]          in_fpr,
  input  logic [CNT_W-1:0]         in_csr_count,
  input  logic [MAX_CSRS*CF_W-1:0] in_csrs,
  output logic                     out_valid,
  output logic [BEAT_W-1:0]        out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [SEQ_W-1:0]         seq_count,
  output logic [15:0]              drop_count
);

  pack_state_t       state;
  logic              in_ready_q;
  logic [BEAT_W-1:0] hold [MAX_BEATS];
  logic [BCW-1:0]    hold_beats;
  logic [BCW-1:0]    idx;
  logic [BCW-1:0]    idx_nxt;
  logic [7:0]        drop_pending;
  logic [7:0]        drop_pending_sat;
  logic [7:0]        hdr_drops;
  logic [15:0]       drop_count_sat;
  logic              drop_evt;

  logic [MAX_L-1:0]  comp_payload;
  logic [LEN_W-1:0]  comp_len;
  logic [BCW-1:0]    comp_beats;
  logic [HOLD_W-1:0] payload_ext;
  logic [BEAT_W-1:0] header_word;
  logic              unused_len;

  rvvi_field_compactor #(
    .XLEN     (XLEN),
    .MAX_CSRS (MAX_CSRS),
    .BEAT_W   (BEAT_W),
    .REQ_W    (REQ_W)
  ) u_compactor (
    .required  (in_required),
    .gpr_wen   (in_gpr_wen),
    .gpr       (in_gpr),
    .fpr_wen   (in_fpr_wen),
    .fpr       (in_fpr),
    .csr_count (in_csr_count),
    .csrs      (in_csrs),
    .payload   (comp_payload),
    .len       (comp_len),
    .beats     (comp_beats)
  );

  // The frame length is informational here; the beat count carries all the FSM needs
  assign unused_len  = ^comp_len;
  assign payload_ext = HOLD_W'(comp_payload);

  // In lossy mode the source is never stalled; otherwise ready tracks IDLE
  assign in_ready = (DROP_ON_FULL != 0) ? 1'b1 : in_ready_q;

  assign drop_evt         = (DROP_ON_FULL != 0) && in_valid && (state != ST_IDLE);
  assign drop_count_sat   = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
  assign drop_pending_sat = (drop_evt && drop_pending != 8'hFF) ? drop_pending + 8'd1 : drop_pending;
  assign idx_nxt          = idx + BCW'(1);

  // Header word built from the incoming frame's beat count and the live counters
  always_comb begin
    header_word = '0;
    header_word[HDR_BEATS_LSB +: HDR_BEATS_W] = HDR_BEATS_W'(comp_beats);
    header_word[HDR_SEQ_LSB +: HDR_SEQ_W]     = seq_count[HDR_SEQ_W-1:0];
    header_word[HDR_DROP_LSB +: HDR_DROP_W]   = drop_pending;
  end

  // Frame FSM, holding register, beat mux and counters, all outputs registered.
  // Drops arriving while a header is stalled stay pending for the next header,
  // so header acceptance removes only the drops that header actually reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      in_ready_q   <= 1'b1;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      seq_count    <= '0;
      drop_count   <= '0;
      drop_pending <= '0;
      hdr_drops    <= '0;
      idx          <= '0;
      hold_beats   <= '0;
    end else begin
      if (drop_evt) begin
        drop_count <= drop_count_sat;
      end
      drop_pending <= drop_pending_sat;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < MAX_BEATS; i++) begin
              hold[i] <= payload_ext[i*BEAT_W +: BEAT_W];
            end
            hold_beats <= comp_beats;
            hdr_drops  <= drop_pending;
            out_data   <= header_word;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            in_ready_q <= 1'b0;
            state      <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (out_ready) begin
            drop_pending <= drop_pending_sat - hdr_drops;
            idx          <= '0;
            out_data     <= hold[0];
            out_last     <= (hold_beats == BCW'(1));
            state        <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_data   <= '0;
              seq_count  <= seq_count + SEQ_W'(1);
              in_ready_q <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              idx      <= idx_nxt;
              out_data <= hold[idx_nxt];
              out_last <= (idx_nxt + BCW'(1) == hold_beats);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvvi_stream_packer.sv
// Self-checking bench for rvvi_stream_packer at default parameters: one
// backpressure-mode instance and one lossy-mode instance share the stimulus.
module tb_rvvi_stream_packer;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [255:0] in_required;
  logic         in_gpr_wen;
  logic [71:0]  in_gpr;
  logic         in_fpr_wen;
  logic [71:0]  in_fpr;
  logic [2:0]   in_csr_count;
  logic [399:0] in_csrs;
  logic         out_ready;

  logic         in_ready0, out_valid0, out_last0;
  logic [31:0]  out_data0;
  logic [15:0]  seq0, drop0;
  logic         in_ready1, out_valid1, out_last1;
  logic [31:0]  out_data1;
  logic [15:0]  seq1, drop1;

  logic         sel;
  logic         ov, ol, ir;
  logic [31:0]  od;
  logic [15:0]  sq, dc;

  int           n_checks = 0;
  int           n_fail = 0;

  logic [31:0]  rx_data [32];
  logic         rx_last [32];
  logic [799:0] exp_bits;
  logic [799:0] exp_saved;
  int           exp_len;

  typedef struct {
    bit       gw;
    bit       fw;
    bit [2:0] cnt;
    bit       toggle;
    int       p;
  } vec_t;

  vec_t vecs [7];

  rvvi_stream_packer #(.DROP_ON_FULL(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_required(in_required), .in_gpr_wen(in_gpr_wen), .in_gpr(in_gpr),
    .in_fpr_wen(in_fpr_wen), .in_fpr(in_fpr), .in_csr_count(in_csr_count),
    .in_csrs(in_csrs), .out_valid(out_valid0), .out_data(out_data0),
    .out_last(out_last0), .out_ready(out_ready), .seq_count(seq0), .drop_count(drop0)
  );

  rvvi_stream_packer #(.DROP_ON_FULL(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_required(in_required), .in_gpr_wen(in_gpr_wen), .in_gpr(in_gpr),
    .in_fpr_wen(in_fpr_wen), .in_fpr(in_fpr), .in_csr_count(in_csr_count),
    .in_csrs(in_csrs), .out_valid(out_valid1), .out_data(out_data1),
    .out_last(out_last1), .out_ready(out_ready), .seq_count(seq1), .drop_count(drop1)
  );

  assign ov = sel ? out_valid1 : out_valid0;
  assign od = sel ? out_data1  : out_data0;
  assign ol = sel ? out_last1  : out_last0;
  assign ir = sel ? in_ready1  : in_ready0;
  assign sq = sel ? seq1       : seq0;
  assign dc = sel ? drop1      : drop0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic appendBits(input logic [255:0] v, input int w);
    for (int b = 0; b < w; b++) exp_bits[exp_len + b] = v[b];
    exp_len += w;
  endtask

  // Randomise a frame's fields and build its expected packed payload bit by bit
  task automatic makeFrame(input bit gw, input bit fw, input bit [2:0] cnt);
    int nc;
    for (int w = 0; w < 8; w++) in_required[w*32 +: 32] = $urandom();
    in_gpr = {$urandom(), $urandom(), 3'b000, 5'($urandom())};
    in_fpr = {$urandom(), $urandom(), 3'b000, 5'($urandom())};
    for (int i = 0; i < 5; i++) in_csrs[i*80 +: 80] = {$urandom(), $urandom(), 4'b0000, 12'($urandom())};
    in_gpr_wen = gw;
    in_fpr_wen = fw;
    in_csr_count = cnt;
    exp_bits = '0;
    exp_len = 0;
    appendBits(in_required, 256);
    if (gw) appendBits({184'b0, in_gpr}, 72);
    if (fw) appendBits({184'b0, in_fpr}, 72);
    nc = (cnt > 3'd5) ? 5 : int'(cnt);
    for (int i = 0; i < nc; i++) appendBits({176'b0, in_csrs[i*80 +: 80]}, 80);
  endtask

  // Offer the current frame for one cycle to an idle DUT
  task automatic applyStimulus();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("accept_latency", ov, 1);
  endtask

  task automatic resetDuts();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Receive header + payload beats, checking stability across stalls
  task automatic collectFrame(input bit toggle, input bit pulses, input bit drop_at_last,
                              output int nb, output bit ready_seen);
    bit          done;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    nb = 0; done = 0; prev_stall = 0; ready_seen = 0; prev_data = '0; prev_last = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      if (pulses) in_valid = (cyc == 3 || cyc == 5 || cyc == 7);
      if (prev_stall) checkOutput("stall_hold", {ov, od, ol}, {1'b1, prev_data, prev_last});
      prev_stall = 0;
      if (ov) begin
        if (ir) ready_seen = 1;
        if (out_ready && nb < 32) begin
          rx_data[nb] = od;
          rx_last[nb] = ol;
          nb++;
          if (ol) begin
            done = 1;
            if (drop_at_last) in_valid = 1'b1;
          end
        end
        prev_stall = !out_ready;
        prev_data = od;
        prev_last = ol;
      end
      @(negedge clk);
    end
    if (pulses || drop_at_last) in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL frame_timeout: got %0d beats, no last beat within budget", nb);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [799:0] model, input int p,
                            input logic [31:0] hdr, input int nb);
    checkOutput({tag, "_beats"}, 64'(nb), 64'(p + 1));
    checkOutput({tag, "_header"}, {rx_data[0], rx_last[0]}, {hdr, 1'b0});
    for (int j = 0; j < p && j + 1 < nb; j++)
      checkOutput($sformatf("%s_payload%0d", tag, j), {rx_data[j+1], rx_last[j+1]},
                  {model[j*32 +: 32], (j == p - 1)});
  endtask

  initial begin
    int nb;
    bit rs;

    // gw, fw, cnt, toggle, P (hand-computed ceil(L/32))
    vecs[0] = '{0, 0, 3'd0, 0, 8};    // 256 bits
    vecs[1] = '{1, 0, 3'd2, 0, 16};   // 488 bits
    vecs[2] = '{1, 1, 3'd5, 1, 25};   // 800 bits, stalled sink
    vecs[3] = '{0, 1, 3'd1, 0, 13};   // 408 bits
    vecs[4] = '{1, 1, 3'd0, 0, 13};   // 400 bits
    vecs[5] = '{0, 0, 3'd7, 0, 21};   // count clamped to 5: 656 bits
    vecs[6] = '{0, 0, 3'd3, 0, 16};   // 496 bits

    sel = 1'b0;
    in_gpr_wen = 0; in_fpr_wen = 0; in_csr_count = '0;
    in_required = '0; in_gpr = '0; in_fpr = '0; in_csrs = '0;
    resetDuts();

    checkOutput("rst_in_ready0", in_ready0, 1);
    checkOutput("rst_out_valid0", out_valid0, 0);
    checkOutput("rst_out_last0", out_last0, 0);
    checkOutput("rst_out_data0", out_data0, 0);
    checkOutput("rst_seq0", seq0, 0);
    checkOutput("rst_drop0", drop0, 0);
    checkOutput("rst_in_ready1", in_ready1, 1);
    checkOutput("rst_out_valid1", out_valid1, 0);
    checkOutput("rst_seq1", seq1, 0);
    checkOutput("rst_drop1", drop1, 0);

    // Table of frame shapes through the backpressure instance
    for (int i = 0; i < 7; i++) begin
      makeFrame(vecs[i].gw, vecs[i].fw, vecs[i].cnt);
      applyStimulus();
      out_ready = 1'b0;
      collectFrame(vecs[i].toggle, 0, 0, nb, rs);
      checkFrame($sformatf("row%0d", i), exp_bits, vecs[i].p,
                 {8'h00, 8'(i), 16'(vecs[i].p)}, nb);
      checkOutput($sformatf("row%0d_seq", i), sq, 64'(i + 1));
      if (i == 1 && nb == 17) begin
        checkOutput("gpr_value_beat8", rx_data[9][31:8], in_gpr[31:8]);
        checkOutput("csr0_addr_beat10", rx_data[11][19:8], in_csrs[11:0]);
        checkOutput("pad_zero_beat15", rx_data[16][31:8], 0);
      end
    end

    // Reset in the middle of a payload abandons the frame and clears counters
    makeFrame(0, 0, 3'd0);
    applyStimulus();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("mid_beat4", {ov, od}, {1'b1, exp_bits[4*32 +: 32]});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_valid", ov, 0);
    checkOutput("mid_rst_seq", sq, 0);
    checkOutput("mid_rst_ready", ir, 1);
    makeFrame(0, 0, 3'd0);
    applyStimulus();
    collectFrame(0, 0, 0, nb, rs);
    checkFrame("post_rst", exp_bits, 8, 32'h0000_0008, nb);

    // Backpressure mode: in_valid held high across two frames
    resetDuts();
    makeFrame(0, 0, 3'd0);
    exp_saved = exp_bits;
    in_valid = 1'b1;
    @(negedge clk);
    makeFrame(0, 1, 3'd1);
    collectFrame(0, 0, 0, nb, rs);
    checkFrame("hold_a", exp_saved, 8, 32'h0000_0008, nb);
    checkOutput("hold_ready_busy", rs, 0);
    checkOutput("hold_ready_idle", ir, 1);
    checkOutput("hold_no_reaccept", ov, 0);
    @(negedge clk);
    in_valid = 1'b0;
    collectFrame(0, 0, 0, nb, rs);
    checkFrame("hold_b", exp_bits, 13, 32'h0001_000D, nb);
    checkOutput("hold_drop", dc, 0);

    // Lossy mode: drops during emission and on the last-beat cycle
    resetDuts();
    sel = 1'b1;
    makeFrame(0, 0, 3'd0);
    applyStimulus();
    collectFrame(0, 1, 0, nb, rs);
    checkFrame("drop_a", exp_bits, 8, 32'h0000_0008, nb);
    checkOutput("drop_count3", dc, 3);
    makeFrame(0, 0, 3'd0);
    applyStimulus();
    collectFrame(0, 0, 1, nb, rs);
    checkFrame("drop_b", exp_bits, 8, 32'h0301_0008, nb);
    checkOutput("drop_count4", dc, 4);
    checkOutput("drop_last_idle", ov, 0);
    makeFrame(0, 0, 3'd0);
    applyStimulus();
    collectFrame(0, 0, 0, nb, rs);
    checkFrame("drop_c", exp_bits, 8, 32'h0102_0008, nb);
    checkOutput("drop_seq", sq, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvvi_stream_packer.md
Name: rvvi_stream_packer

Overview:
Next-generation trace bridge. It takes one compressed RVVI retire frame per cycle, made of a required block, optional GPR/FPR write fields and a variable number of changed CSRs. It drops absent fields, packs the rest contiguously, and serializes the result as a header beat plus BEAT_W-wide payload beats on a valid/ready stream. It sits between the core's trace-capture logic and the Ethernet/UART trace transport, and adds configurable width, CSR count and a lossy/lossless flow-control mode.

Parameters:
XLEN, 64, architectural register width
MAX_CSRS, 5, maximum CSR fields per frame
BEAT_W, 32, output beat width; must be at least 32 and a multiple of 8
REQ_W, 192+XLEN, required-block width (PC, instr, mcycle, minstret, trap, mode, flags; zero-padded)
DROP_ON_FULL, 0, 0 = backpressure the source; 1 = drop frames that arrive while busy
SEQ_W, 16, frame sequence counter width

Ports:
clk  in  1  clock; only clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  frame offered
in_ready  out  1  frame accepted when in_valid & in_ready
in_required  in  REQ_W  required block
in_gpr_wen  in  1  GPR field present
in_gpr  in  XLEN+8  {value, 3'b0, addr[4:0]}
in_fpr_wen  in  1  FPR field present
in_fpr  in  XLEN+8  {value, 3'b0, addr[4:0]}
in_csr_count  in  clog2(MAX_CSRS+1)  number of valid CSR fields; fields 0..count-1 valid
in_csrs  in  MAX_CSRS*(XLEN+16)  field i = {value, 4'b0, addr[11:0]}
out_valid  out  1  beat valid
out_data  out  BEAT_W  beat data
out_last  out  1  final beat of frame
out_ready  in  1  sink accepts beat
seq_count  out  SEQ_W  frames fully emitted
drop_count  out  16  frames dropped; saturates at 0xFFFF

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, seq_count=0, drop_count=0, drop_pending=0. FSM enters IDLE.
- Payload layout, LSB first: required at [REQ_W-1:0]. Then the GPR field if in_gpr_wen, then the FPR field if in_fpr_wen, then CSR fields 0..count-1, all contiguous.
- L = REQ_W + (XLEN+8)·gpr + (XLEN+8)·fpr + count·(XLEN+16).
- P = ceil(L/BEAT_W). The last beat is zero-padded above bit L.
- in_csr_count > MAX_CSRS is clamped to MAX_CSRS.
- Header beat, zero-extended to BEAT_W: [15:0]=P, [23:16]=seq_count[7:0], [31:24]=drop_pending (saturating 8-bit drops since the last header).
- FSM has three states: IDLE, HEADER, PAYLOAD.
  - IDLE: in_ready=1. On acceptance, capture the packed payload and P into the holding register and go to HEADER. Acceptance latency to out_valid is 1 cycle.
  - HEADER: out_valid=1 with header data. On out_ready, clear drop_pending, set beat index=0 and go to PAYLOAD.
  - PAYLOAD: out_data = payload[idx·BEAT_W +: BEAT_W]; out_last=(idx==P-1). On out_ready: if last, increment seq_count (wraps), go to IDLE, in_ready=1 next cycle; otherwise idx++.
- Stream rule: while out_valid & ~out_ready, out_data and out_last hold stable and out_valid holds high.
- DROP_ON_FULL=0: in_ready=0 outside IDLE; no frames are lost.
- DROP_ON_FULL=1: in_ready is tied to 1. in_valid outside IDLE, including the cycle the last beat is accepted, discards the frame and increments drop_count and drop_pending, both saturating.
- Simultaneous last-beat acceptance and in_valid: the frame is dropped (mode 1) or stalled (mode 0). There is no same-cycle re-accept.
- Reset mid-frame abandons the frame. out_valid=0 on the cycle after reset is sampled, and all counters clear.
- Minimum frame: REQ_W only, P = REQ_W/BEAT_W, giving 8 beats at the defaults. Maximum: 800 bits, 25 beats at the defaults.

Decomposition:
- Package rvvi_pkg holds:
  - field widths (GPR_FIELD_W=XLEN+8, CSR_FIELD_W=XLEN+16)
  - header bit offsets
  - a function computing the maximum payload length and beat-index width
- Sub-module rvvi_field_compactor is combinational. It computes field offsets from the enable bits and the count, ORs the shifted fields into the max-length payload vector, and outputs L and P.
- rvvi_stream_packer holds the FSM, holding register, beat mux and counters.

Test Plan:
- Defaults, no GPR/FPR, 0 CSRs, out_ready=1 → header 0x0000_0008, then 8 payload beats equal to in_required[31:0]…[255:224]; out_last on beat 8; seq_count becomes 1.
- gpr_wen=1, CSRs 0 and 1 (count=2) → header P=16 (488 bits). GPR value[23:0] lands at beat 8 bits [31:8], CSR0 addr at bit 328 (beat 10 bit 8). Bits 488..511 of the final beat are 0.
- Full frame (gpr, fpr, count=5) with out_ready toggling 1/0 every cycle → 25 payload beats. Data is stable during stalls and seq_count increments once.
- DROP_ON_FULL=0, in_valid held high across two frames → in_ready=0 during HEADER/PAYLOAD; the second frame is emitted intact afterwards; drop_count=0.
- DROP_ON_FULL=1, three extra frames offered during an 8-beat emission → drop_count=3. The next frame's header is 0x0301_0008.
- Reset asserted at payload beat 4 → out_valid=0 next cycle, seq_count=0, in_ready=1. A subsequent frame starts with header seq 0.
